// File: rtl/payload_streamer.sv
// Consumer end of the PE payload arbitration handshake: pops the granted PE's
// payload words one at a time and streams them on a valid/ready port.
module payload_streamer #(
    parameter int unsigned NUM_PE = 10,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned LEN_W  = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     enable_arbiter,
    input  logic [7:0]               current,
    input  logic [NUM_PE*LEN_W-1:0]  pe_len,
    input  logic [NUM_PE*DATA_W-1:0] pe_rd_data,
    output logic [NUM_PE-1:0]        pe_rd_en,
    output logic [DATA_W-1:0]        out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     out_sop,
    output logic                     out_eop,
    output logic                     last,
    output logic                     busy,
    output logic                     err_grant
);

    localparam int unsigned CUR_W = 8;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        WAIT  = 3'd2,
        SEND  = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t              state, state_d;
    logic [CUR_W-1:0]    idx, idx_d;
    logic [LEN_W-1:0]    remaining, remaining_d;
    logic                first, first_d;
    logic [NUM_PE-1:0]   pe_rd_en_d;
    logic [DATA_W-1:0]   out_data_d;
    logic                out_valid_d, out_sop_d, out_eop_d;
    logic                last_d, busy_d, err_grant_d;

    logic                grant_legal;
    logic [LEN_W-1:0]    grant_len;
    logic [NUM_PE-1:0]   grant_onehot;
    logic [DATA_W-1:0]   idx_data;
    logic [NUM_PE-1:0]   idx_onehot;

    assign grant_legal = 32'(current) < NUM_PE;

    // Per-PE selects by compare loop so an out-of-range index simply selects nothing
    always_comb begin
        grant_len    = '0;
        grant_onehot = '0;
        idx_data     = '0;
        idx_onehot   = '0;
        for (int unsigned i = 0; i < NUM_PE; i++) begin
            if (current == CUR_W'(i)) begin
                grant_len       = pe_len[i*LEN_W +: LEN_W];
                grant_onehot[i] = 1'b1;
            end
            if (idx == CUR_W'(i)) begin
                idx_data      = pe_rd_data[i*DATA_W +: DATA_W];
                idx_onehot[i] = 1'b1;
            end
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d     = state;
        idx_d       = idx;
        remaining_d = remaining;
        first_d     = first;
        pe_rd_en_d  = '0;
        out_data_d  = out_data;
        out_valid_d = out_valid;
        out_sop_d   = out_sop;
        out_eop_d   = out_eop;
        last_d      = 1'b0;
        err_grant_d = 1'b0;

        case (state)
            IDLE: begin
                if (enable_arbiter) begin
                    idx_d   = current;
                    first_d = 1'b1;
                    if (grant_legal) begin
                        remaining_d = grant_len;
                        if (grant_len != '0) begin
                            state_d    = FETCH;
                            pe_rd_en_d = grant_onehot;
                        end else begin
                            state_d = DONE;
                            last_d  = 1'b1;
                        end
                    end else begin
                        remaining_d = '0;
                        err_grant_d = 1'b1;
                        state_d     = DONE;
                        last_d      = 1'b1;
                    end
                end
            end
            FETCH: begin
                state_d = WAIT;
            end
            WAIT: begin
                out_data_d  = idx_data;
                out_eop_d   = (remaining == LEN_W'(1));
                out_sop_d   = first;
                out_valid_d = 1'b1;
                state_d     = SEND;
            end
            SEND: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    out_sop_d   = 1'b0;
                    out_eop_d   = 1'b0;
                    first_d     = 1'b0;
                    remaining_d = remaining - LEN_W'(1);
                    if (remaining > LEN_W'(1)) begin
                        state_d    = FETCH;
                        pe_rd_en_d = idx_onehot;
                    end else begin
                        state_d = DONE;
                        last_d  = 1'b1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A grant arriving while a payload is in flight is dropped and flagged
        if (enable_arbiter && (state != IDLE)) begin
            err_grant_d = 1'b1;
        end

        busy_d = (state_d != IDLE);
    end

    // State and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            idx       <= '0;
            remaining <= '0;
            first     <= 1'b0;
            pe_rd_en  <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            out_sop   <= 1'b0;
            out_eop   <= 1'b0;
            last      <= 1'b0;
            busy      <= 1'b0;
            err_grant <= 1'b0;
        end else begin
            state     <= state_d;
            idx       <= idx_d;
            remaining <= remaining_d;
            first     <= first_d;
            pe_rd_en  <= pe_rd_en_d;
            out_data  <= out_data_d;
            out_valid <= out_valid_d;
            out_sop   <= out_sop_d;
            out_eop   <= out_eop_d;
            last      <= last_d;
            busy      <= busy_d;
            err_grant <= err_grant_d;
        end
    end

endmodule

// File: doc/payload_streamer.md
Name: payload_streamer

Overview:
- Consumer end of the PE payload arbitration handshake.
- The arbiter presents a granted PE index on current and strobes enable_arbiter. This block then pops that PE's payload words through a one-hot read strobe and streams them on a valid/ready output port.
- When the final word is accepted, it pulses last back to the arbiter, which advances its queue.
- Sits between the arbiter/PE buffers and the downstream packet formatter.

Parameters:
- NUM_PE, 10, number of PE payload sources.
- DATA_W, 32, payload word width.
- LEN_W, 8, width of per-PE payload length in words.

Ports:
- clk  input  1  single clock.
- rst_n  input  1  reset, asynchronous, active-low.
- enable_arbiter  input  1  one-cycle grant strobe from the arbiter.
- current  input  8  granted PE index; valid when enable_arbiter=1.
- pe_len  input  NUM_PE*LEN_W  per-PE payload length in words; slice i = PE i.
- pe_rd_data  input  NUM_PE*DATA_W  per-PE read data; valid the cycle after that PE's rd_en.
- pe_rd_en  output  NUM_PE  one-hot pop strobe to the selected PE buffer.
- out_data  output  DATA_W  streamed word.
- out_valid  output  1  out_data valid.
- out_ready  input  1  downstream accept.
- out_sop  output  1  first word of payload; qualified by out_valid.
- out_eop  output  1  final word of payload; qualified by out_valid.
- last  output  1  one-cycle pulse to the arbiter; payload complete.
- busy  output  1  high in any state other than IDLE.
- err_grant  output  1  one-cycle pulse on an illegal grant.

Behaviour:
- Reset (async assert, sync release): state=IDLE; pe_rd_en=0, out_valid=0, out_sop=0, out_eop=0, last=0, err_grant=0; out_data=0; internal idx=0, remaining=0.
- All outputs are registered.
- States: IDLE, FETCH, WAIT, SEND, DONE.
- IDLE: on enable_arbiter=1, latch idx=current.
  - If current<NUM_PE, latch remaining=pe_len[idx].
    - remaining!=0 -> FETCH.
    - remaining==0 -> DONE (no words streamed).
  - If current>=NUM_PE: err_grant pulses next cycle, remaining treated as 0 -> DONE.
- FETCH (one cycle): pe_rd_en[idx]=1, all other bits 0. -> WAIT.
- WAIT (one cycle): sample pe_rd_data slice idx into out_data.
  - Set out_eop = (remaining==1).
  - Set out_sop=1 if this is the first word of the payload.
  - -> SEND.
- SEND: out_valid=1; out_data, out_sop and out_eop are held stable until out_valid&&out_ready.
  - On the handshake, out_valid drops next cycle and remaining decrements.
  - remaining was >1 -> FETCH.
  - remaining was 1 -> DONE.
- DONE (one cycle): last=1. -> IDLE.
- Latencies:
  - enable_arbiter at cycle T -> pe_rd_en at T+1 -> out_valid at T+3.
  - Each later word: out_valid reasserts 3 cycles after the previous handshake.
  - Final handshake at cycle H -> last at H+1 -> IDLE at H+2, where a new enable_arbiter is accepted.
- Zero-length or illegal grant: enable_arbiter at T -> last at T+1; no pe_rd_en, no out_valid.
- enable_arbiter while busy=1 is a protocol violation:
  - The grant is ignored and err_grant pulses next cycle.
  - The current transfer is unaffected.
- out_ready held low indefinitely: block stalls in SEND; no further pe_rd_en.
- pe_len is sampled only at grant. Later changes have no effect on the active payload.
- Length arithmetic: remaining is LEN_W bits. Maximum payload is 2^LEN_W-1 words; no wrap.
- Reset mid-transfer: immediate return to IDLE, all outputs cleared. No last is emitted for the aborted payload.

Test Plan:
- Reset, then grant current=3 with pe_len[3]=2 and out_ready=1 -> pe_rd_en=0x008 at T+1 and at T+4.
  - Two words are output with sop on word 1 and eop on word 2.
  - last pulses exactly once, one cycle after the second handshake.
- Grant current=5 with pe_len[5]=0 -> last=1 at T+1; pe_rd_en and out_valid stay 0.
- Grant current=12 (>=NUM_PE) -> err_grant=1 and last=1 at T+1; no reads issued.
- Grant current=0 with pe_len[0]=3 and out_ready held 0 for 5 cycles on word 2 -> out_data stable while stalled.
  - Exactly 3 pe_rd_en pulses in total; last follows the word-3 handshake.
- Second enable_arbiter (current=7) mid-transfer of PE 1 -> err_grant pulses; PE 1 payload completes unchanged.
  - No pe_rd_en[7] is ever asserted.
- rst_n asserted during SEND of word 2 of 4 -> all outputs 0 immediately and no last.
  - A new grant after release streams correctly from word 1 with sop=1.
